// File: rtl/vga_pattern_gen_if.sv
// Pixel-stream interface between the VGA timing controller and the pattern
// generator: coordinates and mode request in, pixel colour and status out.
interface vga_pattern_gen_if #(
    parameter int PIX_W = 16
);
    logic [11:0]      pix_x;
    logic [11:0]      pix_y;
    logic [2:0]       mode_sel;
    logic [PIX_W-1:0] pix_data;
    logic [2:0]       mode_cur;
    logic [7:0]       frame_cnt;

    // Timing-controller side: drives coordinates and mode request.
    modport master (
        output pix_x, pix_y, mode_sel,
        input  pix_data, mode_cur, frame_cnt
    );

    // Pattern-generator side.
    modport slave (
        input  pix_x, pix_y, mode_sel,
        output pix_data, mode_cur, frame_cnt
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator: colour bars, checkerboard, gray ramp or bouncing
// box, one registered pixel per clock. Mode changes and box motion happen
// only at end of frame so a displayed frame is never torn.
module vga_pattern_gen #(
    parameter int H_VALID    = 640,
    parameter int V_VALID    = 480,
    parameter int BAR_NUM    = 10,
    parameter int PIX_W      = 16,
    parameter int GRID_LOG2  = 5,
    parameter int RAMP_SHIFT = 1,
    parameter int BOX_SIZE   = 64,
    parameter int BOX_STEP   = 2
) (
    input logic             vga_clk,
    input logic             sys_rst_n,
    vga_pattern_gen_if.slave vif
);

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_CHECK = 2'd1,
        MODE_RAMP  = 2'd2,
        MODE_BOX   = 2'd3
    } mode_t;

    // All coordinate arithmetic is 13-bit unsigned so box_x + BOX_SIZE
    // can never wrap.
    localparam logic [12:0] H_LIM     = 13'(H_VALID);
    localparam logic [12:0] V_LIM     = 13'(V_VALID);
    localparam int          BAR_W     = H_VALID / BAR_NUM;
    localparam logic [12:0] BOX_SZ    = 13'(BOX_SIZE);
    localparam logic [12:0] STEP      = 13'(BOX_STEP);
    localparam logic [12:0] BOX_X_MAX = 13'(H_VALID - BOX_SIZE);
    localparam logic [12:0] BOX_Y_MAX = 13'(V_VALID - BOX_SIZE);

    logic [12:0]      x13, y13;
    logic             blank, eof;
    mode_t            mode_q, mode_req;
    logic [7:0]       frame_q;
    logic [12:0]      box_x, box_y;
    logic             dir_x_neg, dir_y_neg;
    logic [13:0]      bounce_x, bounce_y;
    logic [3:0]       bar_idx;
    logic [12:0]      ramp_full;
    logic [7:0]       gray;
    logic             in_box;
    logic [23:0]      rgb;
    logic [PIX_W-1:0] pix_q;

    // Fixed 16-entry RGB888 palette used by the bars.
    function automatic logic [23:0] palette(input logic [3:0] idx);
        case (idx)
            4'd0:    return 24'hFF0000;
            4'd1:    return 24'hFF8000;
            4'd2:    return 24'hFFFF00;
            4'd3:    return 24'h00FF00;
            4'd4:    return 24'h00FFFF;
            4'd5:    return 24'h0000FF;
            4'd6:    return 24'hFF00FF;
            4'd7:    return 24'h000000;
            4'd8:    return 24'hFFFFFF;
            4'd9:    return 24'hD0D0D0;
            4'd10:   return 24'h800000;
            4'd11:   return 24'h008000;
            4'd12:   return 24'h000080;
            4'd13:   return 24'h808000;
            4'd14:   return 24'h008080;
            default: return 24'h800080;
        endcase
    endfunction

    // RGB888 passes through; RGB565 keeps the top bits of each channel.
    function automatic logic [PIX_W-1:0] to_pix(input logic [23:0] c);
        logic [23:0] full;
        full = (PIX_W == 16) ? {8'h00, c[23:19], c[15:10], c[7:3]} : c;
        return full[PIX_W-1:0];
    endfunction

    // One axis of the bounce: returns {new_dir_neg, new_pos}.
    function automatic logic [13:0] bounce(input logic [12:0] pos,
                                           input logic        neg,
                                           input logic [12:0] lim);
        if (!neg) begin
            if (pos + STEP >= lim) return {1'b1, lim};
            else                   return {1'b0, pos + STEP};
        end else begin
            if (pos <= STEP)       return {1'b0, 13'd0};
            else                   return {1'b1, pos - STEP};
        end
    endfunction

    assign x13      = {1'b0, vif.pix_x};
    assign y13      = {1'b0, vif.pix_y};
    assign blank    = (x13 >= H_LIM) || (y13 >= V_LIM);
    assign eof      = (x13 == H_LIM - 13'd1) && (y13 == V_LIM - 13'd1);
    assign mode_req = vif.mode_sel[2] ? MODE_BARS : mode_t'(vif.mode_sel[1:0]);
    assign bounce_x = bounce(box_x, dir_x_neg, BOX_X_MAX);
    assign bounce_y = bounce(box_y, dir_y_neg, BOX_Y_MAX);

    // Bar index from constant thresholds k*BAR_W; the last bar takes the remainder.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        bar_idx = 4'd0;
        for (int k = 1; k < BAR_NUM; k++) begin
            if (x13 >= 13'(k * BAR_W)) bar_idx = 4'(k);
        end
    end

    // Gray level for the ramp, saturated at full white.
    always_comb begin
        ramp_full = x13 >> RAMP_SHIFT;
        gray      = (ramp_full > 13'd255) ? 8'hFF : ramp_full[7:0];
    end

    assign in_box = (x13 >= box_x) && (x13 < box_x + BOX_SZ) &&
                    (y13 >= box_y) && (y13 < box_y + BOX_SZ);

    // Colour of the current coordinate in the active mode.
    always_comb begin
        rgb = 24'h000000;
        if (!blank) begin
            unique case (mode_q)
                MODE_BARS:  rgb = palette(bar_idx);
                MODE_CHECK: rgb = (vif.pix_x[GRID_LOG2] ^ vif.pix_y[GRID_LOG2])
                                  ? 24'h000000 : 24'hFFFFFF;
                MODE_RAMP:  rgb = {gray, gray, gray};
                MODE_BOX:   rgb = in_box ? 24'hFFFFFF : 24'h000080;
                default:    rgb = 24'h000000;
            endcase
        end
    end

    // Registered pixel output.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        // NOTE: state registers use non-blocking assignment so every
        // register samples pre-edge values regardless of statement order.
        if (!sys_rst_n) pix_q <= '0;
        else            pix_q <= to_pix(rgb);
    end

    // Frame-synchronous state: mode, frame counter and box position.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_q    <= MODE_BARS;
            frame_q   <= 8'd0;
            box_x     <= 13'd0;
            box_y     <= 13'd0;
            dir_x_neg <= 1'b0;
            dir_y_neg <= 1'b0;
        end else if (eof) begin
            mode_q    <= mode_req;
            frame_q   <= frame_q + 8'd1;
            dir_x_neg <= bounce_x[13];
            box_x     <= bounce_x[12:0];
            dir_y_neg <= bounce_y[13];
            box_y     <= bounce_y[12:0];
        end
    end

    assign vif.pix_data  = pix_q;
    assign vif.mode_cur  = {1'b0, mode_q};
    assign vif.frame_cnt = frame_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench: two generator instances (RGB565 with 10 bars, RGB888
// with 3 bars) checked against a behavioural model of the pattern rules.
module tb_vga_pattern_gen;

    localparam int H    = 640;
    localparam int V    = 480;
    localparam int BOX  = 64;
    localparam int STEP = 2;

    localparam logic [23:0] PAL [16] = '{
        24'hFF0000, 24'hFF8000, 24'hFFFF00, 24'h00FF00,
        24'h00FFFF, 24'h0000FF, 24'hFF00FF, 24'h000000,
        24'hFFFFFF, 24'hD0D0D0, 24'h800000, 24'h008000,
        24'h000080, 24'h808000, 24'h008080, 24'h800080
    };

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    // Model state.
    int m_mode, m_frame, m_bx, m_by;
    bit m_nx, m_ny;

    always #5 clk = ~clk;

    vga_pattern_gen_if #(.PIX_W(16)) if0 ();
    vga_pattern_gen_if #(.PIX_W(24)) if1 ();

    vga_pattern_gen #(.PIX_W(16)) u_dut0 (
        .vga_clk   (clk),
        .sys_rst_n (rst_n),
        .vif       (if0)
    );

    vga_pattern_gen #(.PIX_W(24), .BAR_NUM(3)) u_dut1 (
        .vga_clk   (clk),
        .sys_rst_n (rst_n),
        .vif       (if1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to565(input logic [23:0] c);
        return {c[23:19], c[15:10], c[7:3]};
    endfunction

    // Expected RGB888 colour straight from the pattern definitions.
    function automatic logic [23:0] ref_rgb(input int x, input int y, input int mode,
                                            input int bx, input int by, input int barnum);
        int bw, idx, g;
        logic [7:0] g8;
        if (x >= H || y >= V) return 24'h000000;
        case (mode)
            0: begin
                bw  = H / barnum;
                idx = x / bw;
                if (idx > barnum - 1) idx = barnum - 1;
                return PAL[idx];
            end
            1: return ((((x / 32) + (y / 32)) % 2) == 0) ? 24'hFFFFFF : 24'h000000;
            2: begin
                g = x / 2;
                if (g > 255) g = 255;
                g8 = 8'(g);
                return {g8, g8, g8};
            end
            default:
                return (x >= bx && x < bx + BOX && y >= by && y < by + BOX)
                       ? 24'hFFFFFF : 24'h000080;
        endcase
    endfunction

    task automatic bounce(inout int p, inout bit neg, input int lim);
        if (!neg) begin
            if (p + STEP >= lim) begin p = lim; neg = 1'b1; end
            else p = p + STEP;
        end else begin
            if (p <= STEP) begin p = 0; neg = 1'b0; end
            else p = p - STEP;
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_frame = 0; m_bx = 0; m_by = 0; m_nx = 1'b0; m_ny = 1'b0;
    endtask

    // One clock: present inputs, advance model, check outputs after the edge.
    task automatic step(input int x, input int y, input int m);
        logic [23:0] e0, e1;
        @(negedge clk);
        if0.pix_x = 12'(x); if0.pix_y = 12'(y); if0.mode_sel = 3'(m);
        if1.pix_x = 12'(x); if1.pix_y = 12'(y); if1.mode_sel = 3'(m);
        e0 = ref_rgb(x, y, m_mode, m_bx, m_by, 10);
        e1 = ref_rgb(x, y, m_mode, m_bx, m_by, 3);
        if (x == H - 1 && y == V - 1) begin
            m_mode  = (m > 3) ? 0 : m;
            m_frame = (m_frame + 1) % 256;
            bounce(m_bx, m_nx, H - BOX);
            bounce(m_by, m_ny, V - BOX);
        end
        @(posedge clk);
        #1;
        check($sformatf("pix16 x=%0d y=%0d", x, y), 32'(if0.pix_data), 32'(to565(e0)));
        check($sformatf("pix24 x=%0d y=%0d", x, y), 32'(if1.pix_data), 32'(e1));
        check("mode_cur", 32'(if0.mode_cur), 32'(m_mode));
        check("frame_cnt", 32'(if0.frame_cnt), 32'(m_frame));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " pix16"}, 32'(if0.pix_data), 32'h0);
        check({tag, " pix24"}, 32'(if1.pix_data), 32'h0);
        check({tag, " mode"},  32'(if0.mode_cur), 32'h0);
        check({tag, " frame"}, 32'(if0.frame_cnt), 32'h0);
    endtask

    initial begin
        int x, y;
        if0.pix_x = '0; if0.pix_y = '0; if0.mode_sel = '0;
        if1.pix_x = '0; if1.pix_y = '0; if1.mode_sel = '0;
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_reset_state("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Bars across a full line, plus blanking.
        for (int i = 0; i < H; i++) step(i, 0, 0);
        step(700, 0, 0);
        step(H, 10, 0);
        step(10, V, 0);
        foreach (PAL[i]) if (i < 3) step(212 + i * 213, 5, 0);

        // Mode switch requested mid-frame takes effect only after EOF.
        step(100, 100, 1);
        step(H - 2, V - 1, 1);
        step(H - 1, V - 2, 1);
        step(H - 1, V - 1, 1);
        step(0, 0, 1);
        step(32, 0, 1);
        step(32, 32, 1);

        // Ramp including saturation.
        step(H - 1, V - 1, 2);
        step(100, 3, 2);
        step(510, 3, 2);
        step(600, 3, 2);

        // Randomized traffic with occasional EOFs and out-of-range modes.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                x = H - 1; y = V - 1;
            end else if ($urandom_range(0, 7) == 0) begin
                x = $urandom_range(H - 2, H + 1); y = $urandom_range(V - 2, V + 1);
            end else begin
                x = $urandom_range(0, 799); y = $urandom_range(0, 599);
            end
            step(x, y, int'($urandom_range(0, 7)));
        end

        // Fresh start, ten frames in, then asynchronous reset mid-line.
        @(negedge clk); rst_n = 1'b0; model_reset();
        @(negedge clk); rst_n = 1'b1;
        for (int f = 0; f < 10; f++) begin
            step(H - 1, V - 1, 3);
            step(m_bx, m_by, 3);
        end
        @(negedge clk);
        if0.pix_x = 12'd320; if1.pix_x = 12'd320;
        #2 rst_n = 1'b0;
        #1 check_reset_state("midreset");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 3);

        // Box over 300 frames: corners and edges probed every frame.
        for (int f = 0; f < 300; f++) begin
            step(H - 1, V - 1, 3);
            step(m_bx, m_by, 3);
            step(m_bx + BOX - 1, m_by + BOX - 1, 3);
            step(m_bx + BOX, m_by, 3);
            step(m_bx, m_by + BOX, 3);
            if (m_bx > 0) step(m_bx - 1, m_by, 3);
            if (m_by > 0) step(m_bx, m_by - 1, 3);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
